// File: rtl/cy_mlp.sv
// Single-layer MLP digit classifier: AXI-stream pixels in, AXI4-Lite weights/control/result.
// Define WEIGHT_PRELOAD_EN to keep weights/biases across resets.
module cy_mlp #(
  parameter int unsigned dataWidth   = 16,
  parameter int unsigned NUM_INPUTS  = 64,
  parameter int unsigned NUM_CLASSES = 10
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_aresetn,
  input  logic [31:0]          s_axi_awaddr,
  input  logic [2:0]           s_axi_awprot,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [31:0]          s_axi_araddr,
  input  logic [2:0]           s_axi_arprot,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  input  logic [dataWidth-1:0] axis_in_data,
  input  logic                 axis_in_data_valid,
  output logic                 axis_in_data_ready,
  output logic                 intr
);
  localparam int unsigned NumWeights = NUM_INPUTS * NUM_CLASSES;
  localparam int unsigned ProdW      = 2 * dataWidth;
  localparam int unsigned AccW       = 2 * dataWidth + 7;
  localparam int unsigned PtrW       = $clog2(NumWeights);
  localparam int unsigned PixW       = $clog2(NUM_INPUTS);
  localparam int unsigned ClsW       = $clog2(NUM_CLASSES + 1);
  localparam int unsigned BptrW      = $clog2(NUM_CLASSES);

  typedef enum logic [1:0] {StLoad, StCompute, StCmp, StDone} state_e;

  state_e                      state_q, state_d;
  logic signed [dataWidth-1:0] weight_q [NumWeights];
  logic signed [dataWidth-1:0] bias_q   [NUM_CLASSES];
  logic signed [dataWidth-1:0] pix_q    [NUM_INPUTS];
  logic [PtrW-1:0]             ptr_q;
  logic [BptrW-1:0]            bptr_q;
  logic [PixW-1:0]             cnt_q, idx_q;
  logic [ClsW-1:0]             cls_q, best_idx_q, result_q;
  logic signed [AccW-1:0]      acc_q, best_q;
  logic                        intr_q, done_q;
  logic                        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]                 rdata_q, rd_val;

  logic                        wr_fire, rd_fire, soft_rst, pix_fire, last_pix, last_mac, cmp_en;
  logic [2:0]                  wr_sel, rd_sel;
  logic [PtrW-1:0]             w_addr;
  logic signed [ProdW-1:0]     prod;
  logic signed [dataWidth-1:0] bias_cur;
  logic signed [AccW-1:0]      bias_ext, mac_sum;

  assign wr_fire  = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire  = arready_q & s_axi_arvalid;
  assign wr_sel   = s_axi_awaddr[4:2];
  assign rd_sel   = s_axi_araddr[4:2];
  assign soft_rst = wr_fire && (wr_sel == 3'd7) && s_axi_wdata[0];
  assign pix_fire = axis_in_data_valid && (state_q == StLoad);
  assign last_pix = (cnt_q == PixW'(NUM_INPUTS - 1));
  assign last_mac = (idx_q == PixW'(NUM_INPUTS - 1)) && (cls_q == ClsW'(NUM_CLASSES - 1));
  // acc_q holds the finished sum of class cls_q-1 at the first MAC of the next class and in StCmp.
  assign cmp_en   = (state_q == StCompute && idx_q == '0 && cls_q != '0) || (state_q == StCmp);

  assign w_addr   = PtrW'(cls_q) * PtrW'(NUM_INPUTS) + PtrW'(idx_q);
  assign prod     = pix_q[idx_q] * weight_q[w_addr];
  assign bias_cur = bias_q[cls_q[BptrW-1:0]];
  // Bias shares the pixel/weight Q format; shift it onto the product's binary point.
  assign bias_ext = {{(AccW - dataWidth){bias_cur[dataWidth-1]}}, bias_cur} <<< (dataWidth - 1);
  assign mac_sum  = ((idx_q == '0) ? bias_ext : acc_q) + {{(AccW - ProdW){prod[ProdW-1]}}, prod};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:    if (pix_fire && last_pix) state_d = StCompute;
      StCompute: if (last_mac) state_d = StCmp;
      StCmp:     state_d = StDone;
      StDone:    state_d = StLoad;
      default:   state_d = StLoad;
    endcase
    if (soft_rst) state_d = StLoad;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
    if (s_axi_aresetn) state_q <= StLoad;
    else               state_q <= state_d;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
    if (s_axi_aresetn || soft_rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      cls_q      <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      result_q   <= '0;
      intr_q     <= 1'b0;
      done_q     <= 1'b0;
      ptr_q      <= '0;
      bptr_q     <= '0;
    end else begin
      if (pix_fire) cnt_q <= last_pix ? '0 : cnt_q + 1'b1;
      if (pix_fire && last_pix) begin
        idx_q <= '0;
        cls_q <= '0;
      end
      if (state_q == StCompute) begin
        acc_q <= mac_sum;
        if (idx_q == PixW'(NUM_INPUTS - 1)) begin
          idx_q <= '0;
          cls_q <= cls_q + 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
      if (cmp_en && (cls_q == ClsW'(1) || acc_q > best_q)) begin
        best_q     <= acc_q;
        best_idx_q <= cls_q - 1'b1;
      end
      if (state_q == StDone) begin
        result_q <= best_idx_q;
        intr_q   <= 1'b1;
        done_q   <= 1'b1;
      end else if ((rd_fire && rd_sel == 3'd2) || (wr_fire && wr_sel == 3'd7)) begin
        intr_q <= 1'b0;
        done_q <= 1'b0;
      end
      if (wr_fire) begin
        case (wr_sel)
          3'd0: ptr_q <= (ptr_q == PtrW'(NumWeights - 1)) ? '0 : ptr_q + 1'b1;
          3'd1: bptr_q <= (bptr_q == BptrW'(NUM_CLASSES - 1)) ? '0 : bptr_q + 1'b1;
          3'd3: begin
            ptr_q  <= '0;
            bptr_q <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (pix_fire) pix_q[cnt_q] <= axis_in_data;
  end

`ifdef WEIGHT_PRELOAD_EN
  always_ff @(posedge s_axi_aclk) begin
    if (wr_fire && wr_sel == 3'd0) weight_q[ptr_q] <= s_axi_wdata[dataWidth-1:0];
    if (wr_fire && wr_sel == 3'd1) bias_q[bptr_q] <= s_axi_wdata[dataWidth-1:0];
  end
`else
  always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
    if (s_axi_aresetn) begin
      for (int i = 0; i < NumWeights; i++) weight_q[i] <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) bias_q[i] <= '0;
    end else begin
      if (wr_fire && wr_sel == 3'd0) weight_q[ptr_q] <= s_axi_wdata[dataWidth-1:0];
      if (wr_fire && wr_sel == 3'd1) bias_q[bptr_q] <= s_axi_wdata[dataWidth-1:0];
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (rd_sel)
      3'd2:    rd_val = 32'(result_q);
      3'd6:    rd_val = {30'd0, done_q, state_q != StLoad};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
    if (s_axi_aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (bvalid_q && s_axi_bready) bvalid_q <= 1'b0;
      if (wr_fire) begin
        awready_q <= 1'b0;
        bvalid_q  <= 1'b1;
      end else if (!awready_q && !bvalid_q && s_axi_awvalid && s_axi_wvalid) begin
        awready_q <= 1'b1;
      end
      if (rvalid_q && s_axi_rready) rvalid_q <= 1'b0;
      if (rd_fire) begin
        arready_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rdata_q   <= rd_val;
      end else if (!arready_q && !rvalid_q && s_axi_arvalid) begin
        arready_q <= 1'b1;
      end
    end
  end

  assign s_axi_awready      = awready_q;
  assign s_axi_wready       = awready_q;
  assign s_axi_bresp        = 2'b00;
  assign s_axi_bvalid       = bvalid_q;
  assign s_axi_arready      = arready_q;
  assign s_axi_rdata        = rdata_q;
  assign s_axi_rresp        = 2'b00;
  assign s_axi_rvalid       = rvalid_q;
  assign axis_in_data_ready = (state_q == StLoad);
  assign intr               = intr_q;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_wstrb, s_axi_arprot, s_axi_awaddr[31:5],
                           s_axi_awaddr[1:0], s_axi_araddr[31:5], s_axi_araddr[1:0],
                           s_axi_wdata[31:dataWidth]};

endmodule

// File: tb/tb_cy_mlp.sv
// Directed bench for cy_mlp: register map, classification results, latency, soft reset and
// AXI back-pressure.
module tb_cy_mlp;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [15:0] axis_data;
  logic        axis_valid, axis_ready, intr;

  int checks = 0;
  int errors = 0;
  int intr_rises = 0;

  always #5 clk = ~clk;
  always @(posedge intr) intr_rises++;

  cy_mlp dut (
    .s_axi_aclk        (clk),
    .s_axi_aresetn     (rst),
    .s_axi_awaddr      (awaddr),
    .s_axi_awprot      (awprot),
    .s_axi_awvalid     (awvalid),
    .s_axi_awready     (awready),
    .s_axi_wdata       (wdata),
    .s_axi_wstrb       (wstrb),
    .s_axi_wvalid      (wvalid),
    .s_axi_wready      (wready),
    .s_axi_bresp       (bresp),
    .s_axi_bvalid      (bvalid),
    .s_axi_bready      (bready),
    .s_axi_araddr      (araddr),
    .s_axi_arprot      (arprot),
    .s_axi_arvalid     (arvalid),
    .s_axi_arready     (arready),
    .s_axi_rdata       (rdata),
    .s_axi_rresp       (rresp),
    .s_axi_rvalid      (rvalid),
    .s_axi_rready      (rready),
    .axis_in_data      (axis_data),
    .axis_in_data_valid(axis_valid),
    .axis_in_data_ready(axis_ready),
    .intr              (intr)
  );

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL axi_write_timeout addr=%h", addr); end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin checks++; errors++; $display("FAIL axi_read_timeout addr=%h", addr); end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    data = rdata;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // Every weight of class cls gets val, all others 0 (cls = -1 clears everything).
  task automatic load_weights(input int cls, input logic [15:0] val);
    axi_write(32'h0C, 32'd0);
    for (int i = 0; i < 640; i++) axi_write(32'h00, (i / 64 == cls) ? {16'd0, val} : 32'd0);
  endtask

  task automatic load_biases(input int cls, input logic [15:0] val);
    axi_write(32'h0C, 32'd0);
    for (int i = 0; i < 10; i++) axi_write(32'h04, (i == cls) ? {16'd0, val} : 32'd0);
  endtask

  task automatic send_pixels(input int cnt, input logic [15:0] val);
    int w;
    @(negedge clk);
    for (int i = 0; i < cnt; i++) begin
      axis_data = val; axis_valid = 1'b1;
      w = 0;
      while (!axis_ready && w < 1000) begin @(negedge clk); w++; end
      if (w >= 1000) begin checks++; errors++; $display("FAIL pixel_ready_timeout pix=%0d", i); end
      @(negedge clk);
    end
    axis_valid = 1'b0;
  endtask

  // Cycles from the last accepted pixel until intr is seen high (2000 means it never rose).
  task automatic wait_intr(output int n);
    n = 0;
    while (!intr && n < 2000) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_intr got %b want 0", intr); end
    checks++;
    if (axis_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", axis_ready); end
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL rst_axi_ready got %b want 000", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin
      errors++; $display("FAIL rst_axi_valid got %b want 00", {bvalid, rvalid});
    end
    axi_read(32'h18, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_status got %h want 0", d); end
    axi_read(32'h08, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_result got %h want 0", d); end
  endtask

  task automatic test_zero_tie();
    logic [31:0] d;
    int n;
    send_pixels(64, 16'h0100);
    wait_intr(n);
    checks++; if (n !== 642) begin errors++; $display("FAIL zero_latency got %0d want 642", n); end
    axi_read(32'h18, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL zero_status_done got %h want 2", d); end
    axi_read(32'h08, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL zero_result got %0d want 0", d); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL zero_intr_clr got %b want 0", intr); end
    axi_read(32'h18, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL zero_status_clr got %h want 0", d); end
  endtask

  task automatic test_class3();
    logic [31:0] d;
    int n;
    load_weights(3, 16'h0100);
    send_pixels(64, 16'h0100);
    wait_intr(n);
    checks++; if (n !== 642) begin errors++; $display("FAIL c3_latency got %0d want 642", n); end
    axi_read(32'h08, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL c3_result got %0d want 3", d); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL c3_intr_clr got %b want 0", intr); end
  endtask

  task automatic test_bias7();
    logic [31:0] d;
    int n;
    load_weights(-1, 16'h0000);
    load_biases(7, 16'h7FFF);
    send_pixels(64, 16'h0100);
    wait_intr(n);
    checks++; if (n !== 642) begin errors++; $display("FAIL b7_latency got %0d want 642", n); end
    axi_read(32'h08, d);
    checks++; if (d !== 32'd7) begin errors++; $display("FAIL b7_result got %0d want 7", d); end
    load_biases(-1, 16'h0000);
    send_pixels(64, 16'h0100);
    wait_intr(n);
    axi_read(32'h08, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL b0_result got %0d want 0", d); end
  endtask

  // Class 2 is strongly negative, class 4 slightly positive through its bias.
  task automatic test_signed();
    logic [31:0] d;
    int n;
    load_weights(2, 16'hFF00);
    load_biases(4, 16'h0001);
    send_pixels(64, 16'h0100);
    wait_intr(n);
    axi_read(32'h08, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL signed_result got %0d want 4", d); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] d;
    int n;
    load_weights(5, 16'h0100);
    load_biases(-1, 16'h0000);
    send_pixels(30, 16'hFF00);
    axi_write(32'h1C, 32'd1);
    intr_rises = 0;
    checks++;
    if (axis_ready !== 1'b1) begin errors++; $display("FAIL srst_ready got %b want 1", axis_ready); end
    send_pixels(64, 16'h0100);
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL srst_early_intr got %b want 0", intr); end
    wait_intr(n);
    checks++; if (n !== 642) begin errors++; $display("FAIL srst_latency got %0d want 642", n); end
    repeat (20) @(posedge clk);
    checks++;
    if (intr_rises !== 1) begin errors++; $display("FAIL srst_intr_count got %0d want 1", intr_rises); end
    axi_read(32'h08, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL srst_result got %0d want 5", d); end
  endtask

  task automatic test_axi_hold();
    logic [31:0] d;
    int n;
    @(negedge clk);
    awaddr = 32'h14; wdata = 32'hFFFF_FFFF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL hold_aw_timeout got %0d want <50", n); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bvalid, awready} !== 2'b10) begin
        errors++; $display("FAIL hold_b cyc=%0d got %b want 10", i, {bvalid, awready});
      end
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL hold_b_clr got %b want 0", bvalid); end
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL hold_ar_timeout got %0d want <50", n); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rvalid, arready, rdata} !== {2'b10, 32'd0}) begin
        errors++; $display("FAIL hold_r cyc=%0d got %b/%h want 10/0", i, {rvalid, arready}, rdata);
      end
      @(negedge clk);
    end
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL hold_r_clr got %b want 0", rvalid); end
    axi_read(32'h08, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL hold_result_kept got %0d want 5", d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = 4'hF;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    axis_data = '0; axis_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_zero_tie();
    test_class3();
    test_bias7();
    test_signed();
    test_soft_reset();
    test_axi_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
